onehot_decoder: RTL and testbench

//  Converts a one-hot word back to its binary index; the inverse of the team's onehot_encoder.
//  Two-stage registered pipeline with valid/ready handshakes on both sides.

---
 rtl/onehot_decoder_if.sv | 27 ++
 rtl/onehot_decoder.sv | 78 +++++++
 tb/tb_onehot_decoder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_decoder_if.sv
// Handshake bundle for onehot_decoder: one-hot request stream in, decoded result stream out.
// master drives the input word and output ready; slave is the decoder side.
interface onehot_decoder_if #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 4,
    parameter int ERRCNT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     datain;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    dataout;
    logic                err;
    logic                multi;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output in_valid, datain, out_ready,
        input  in_ready, out_valid, dataout, err, multi, err_count
    );

    modport slave (
        input  in_valid, datain, out_ready,
        output in_ready, out_valid, dataout, err, multi, err_count
    );
endinterface

// File: rtl/onehot_decoder.sv
// One-hot to binary index decoder with illegal-code flags and a saturating error count.
// Latency 2 cycles; in_ready drops only when both stages hold data and the output is stalled.
module onehot_decoder #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 4,
    parameter int ERRCNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    onehot_decoder_if.slave  bus
);

    typedef struct packed {
        logic [OUT_W-1:0] idx;
        logic             err;
        logic             multi;
    } res_t;

    logic                s1_v;
    logic [IN_W-1:0]     s1_d;
    logic                s2_v;
    res_t                res_q;
    res_t                dec;
    logic [ERRCNT_W-1:0] err_count_q;
    logic                s1_adv;
    logic                s2_adv;
    logic                out_xfer;

    assign s2_adv   = !s2_v || bus.out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign out_xfer = s2_v && bus.out_ready;

    assign bus.in_ready  = s1_adv && !rst;
    assign bus.out_valid = s2_v;
    assign bus.dataout   = res_q.idx;
    assign bus.err       = res_q.err;
    assign bus.multi     = res_q.multi;
    assign bus.err_count = err_count_q;

    // Downward scan leaves the lowest set bit as the final winner.
    always_comb begin
        dec       = '0;
        dec.multi = |(s1_d & (s1_d - IN_W'(1)));
        dec.err   = ~(|s1_d) | dec.multi;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (s1_d[i]) begin
                dec.idx = OUT_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v        <= 1'b0;
            s1_d        <= '0;
            s2_v        <= 1'b0;
            res_q       <= '0;
            err_count_q <= '0;
        end else begin
            if (s1_adv) begin
                s1_v <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_d <= bus.datain;
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    res_q <= dec;
                end
            end
            if (out_xfer && res_q.err && (err_count_q != '1)) begin
                err_count_q <= err_count_q + ERRCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed and randomised checks of onehot_decoder, including a 2-bit error counter instance.
module tb_onehot_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    onehot_decoder_if #(.IN_W(16), .OUT_W(4), .ERRCNT_W(8)) bus ();
    onehot_decoder_if #(.IN_W(16), .OUT_W(4), .ERRCNT_W(2)) bus2 ();

    onehot_decoder #(.IN_W(16), .OUT_W(4), .ERRCNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    onehot_decoder #(.IN_W(16), .OUT_W(4), .ERRCNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       ir;
        logic       ov;
        logic [3:0] d;
        logic       e;
        logic       m;
        logic [7:0] ec;
    } snap_t;

    // Drive one cycle of inputs, capture outputs before the edge, return just after it.
    task automatic cycle(input logic v, input logic [15:0] d, input logic ordy, output snap_t s);
        bus.in_valid  = v;
        bus.datain    = d;
        bus.out_ready = ordy;
        #2;
        s.ir = bus.in_ready;
        s.ov = bus.out_valid;
        s.d  = bus.dataout;
        s.e  = bus.err;
        s.m  = bus.multi;
        s.ec = bus.err_count;
        @(posedge clk);
        #1;
    endtask

    // Reference decode: {idx, err, multi}
    function automatic logic [5:0] ref_dec(input logic [15:0] x);
        int n;
        logic [3:0] idx;
        n   = $countones(x);
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) begin
                idx = 4'(i);
                break;
            end
        end
        return {idx, (n != 1), (n > 1)};
    endfunction

    task automatic test_reset;
        snap_t s;
        rst = 1'b1;
        cycle(1'b1, 16'h0001, 1'b1, s);
        total++; if (s.ir !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", s.ir); end
        cycle(1'b1, 16'h0001, 1'b1, s);
        rst = 1'b0;
        cycle(1'b0, 16'h0000, 1'b1, s);
        total++; if (s.ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", s.ov); end
        total++; if (s.d !== 4'd0) begin bad++; $display("FAIL reset_dataout got=%0d exp=0", s.d); end
        total++; if ({s.e, s.m} !== 2'b00) begin bad++; $display("FAIL reset_err_multi got=%b exp=00", {s.e, s.m}); end
        total++; if (s.ec !== 8'd0) begin bad++; $display("FAIL reset_err_count got=%0d exp=0", s.ec); end
        total++; if (s.ir !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", s.ir); end
    endtask

    task automatic test_sweep;
        snap_t s;
        logic [15:0] one;
        one = 16'h0001;
        for (int c = 0; c < 19; c++) begin
            cycle(c < 16, one << (c % 16), 1'b1, s);
            if (c < 16) begin
                total++; if (s.ir !== 1'b1) begin bad++; $display("FAIL sweep_in_ready c=%0d got=%b exp=1", c, s.ir); end
            end
            if (c < 2 || c > 17) begin
                total++; if (s.ov !== 1'b0) begin bad++; $display("FAIL sweep_idle c=%0d out_valid=%b exp=0", c, s.ov); end
            end else begin
                total++;
                if (s.ov !== 1'b1 || s.d !== 4'(c - 2) || s.e !== 1'b0 || s.m !== 1'b0) begin
                    bad++;
                    $display("FAIL sweep_result c=%0d got v=%b d=%0d e=%b m=%b exp v=1 d=%0d e=0 m=0",
                             c, s.ov, s.d, s.e, s.m, c - 2);
                end
            end
        end
    endtask

    task automatic test_illegal;
        snap_t s;
        cycle(1'b1, 16'h0000, 1'b1, s);
        cycle(1'b1, 16'h0090, 1'b1, s);
        cycle(1'b0, 16'h0000, 1'b1, s);
        total++;
        if (s.ov !== 1'b1 || s.d !== 4'd0 || s.e !== 1'b1 || s.m !== 1'b0 || s.ec !== 8'd0) begin
            bad++;
            $display("FAIL zero_word got v=%b d=%0d e=%b m=%b ec=%0d exp v=1 d=0 e=1 m=0 ec=0", s.ov, s.d, s.e, s.m, s.ec);
        end
        cycle(1'b0, 16'h0000, 1'b1, s);
        total++;
        if (s.ov !== 1'b1 || s.d !== 4'd4 || s.e !== 1'b1 || s.m !== 1'b1 || s.ec !== 8'd1) begin
            bad++;
            $display("FAIL multi_word got v=%b d=%0d e=%b m=%b ec=%0d exp v=1 d=4 e=1 m=1 ec=1", s.ov, s.d, s.e, s.m, s.ec);
        end
        cycle(1'b0, 16'h0000, 1'b1, s);
        total++; if (s.ov !== 1'b0 || s.ec !== 8'd2) begin bad++; $display("FAIL illegal_count got v=%b ec=%0d exp v=0 ec=2", s.ov, s.ec); end
    endtask

    task automatic test_backpressure;
        snap_t s;
        logic [15:0] words [4];
        int i = 0;
        int nd = 0;
        words = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
        for (int c = 0; c < 11; c++) begin
            cycle(i < 4, (i < 4) ? words[i] : 16'h0000, c >= 5, s);
            if (c >= 2 && c <= 4) begin
                total++;
                if (s.ir !== 1'b0 || s.ov !== 1'b1 || s.d !== 4'd0) begin
                    bad++;
                    $display("FAIL stall c=%0d got ir=%b v=%b d=%0d exp ir=0 v=1 d=0", c, s.ir, s.ov, s.d);
                end
            end
            if (s.ov && c >= 5) begin
                total++;
                if (nd > 3 || s.d !== 4'(nd) || s.e !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_order n=%0d got d=%0d e=%b exp d=%0d e=0", nd, s.d, s.e, nd);
                end
                nd++;
            end
            if (i < 4 && s.ir) i++;
        end
        total++; if (i !== 4 || nd !== 4) begin bad++; $display("FAIL bp_counts got acc=%0d del=%0d exp 4 4", i, nd); end
    endtask

    task automatic test_random;
        snap_t s;
        logic [5:0] q [$];
        logic [5:0] e;
        logic [5:0] prev;
        logic prev_stall = 1'b0;
        logic v = 1'b0;
        logic ordy;
        logic [15:0] d = 16'h0000;
        logic [15:0] one = 16'h0001;
        logic [7:0] exp_ec = 8'd2;
        int acc = 0;
        int del = 0;
        int cyc = 0;
        while ((acc < 200 || del < acc) && cyc < 5000) begin
            if (!v && acc < 200 && ($urandom % 4) != 0) begin
                v = 1'b1;
                case ($urandom % 4)
                    0:       d = one << ($urandom % 16);
                    1:       d = 16'h0000;
                    default: d = 16'($urandom_range(0, 65535));
                endcase
            end
            ordy = ($urandom % 3) != 0;
            cycle(v, d, ordy, s);
            total++; if (s.ec !== exp_ec) begin bad++; $display("FAIL rnd_err_count cyc=%0d got=%0d exp=%0d", cyc, s.ec, exp_ec); end
            if (prev_stall) begin
                total++;
                if (s.ov !== 1'b1 || {s.d, s.e, s.m} !== prev) begin
                    bad++;
                    $display("FAIL rnd_hold cyc=%0d got v=%b res=%h exp v=1 res=%h", cyc, s.ov, {s.d, s.e, s.m}, prev);
                end
            end
            if (s.ov && ordy) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_spurious cyc=%0d got res=%h exp none", cyc, {s.d, s.e, s.m});
                end else begin
                    e = q.pop_front();
                    if ({s.d, s.e, s.m} !== e) begin
                        bad++;
                        $display("FAIL rnd_result n=%0d got d=%0d e=%b m=%b exp d=%0d e=%b m=%b",
                                 del, s.d, s.e, s.m, e[5:2], e[1], e[0]);
                    end
                    if (e[1] && exp_ec != 8'hff) exp_ec++;
                end
                del++;
            end
            prev_stall = s.ov && !ordy;
            prev       = {s.d, s.e, s.m};
            if (v && s.ir) begin
                q.push_back(ref_dec(d));
                acc++;
                v = 1'b0;
            end
            cyc++;
        end
        total++; if (del !== 200 || cyc >= 5000) begin bad++; $display("FAIL rnd_complete got del=%0d cyc=%0d exp del=200 within 5000", del, cyc); end
    endtask

    task automatic test_reset_flush;
        snap_t s;
        cycle(1'b1, 16'h0000, 1'b0, s);
        cycle(1'b1, 16'h0000, 1'b0, s);
        cycle(1'b1, 16'h0003, 1'b0, s);
        total++; if (s.ir !== 1'b0 || s.ov !== 1'b1) begin bad++; $display("FAIL flush_full got ir=%b v=%b exp ir=0 v=1", s.ir, s.ov); end
        rst = 1'b1;
        cycle(1'b1, 16'h0008, 1'b1, s);
        total++; if (s.ir !== 1'b0) begin bad++; $display("FAIL flush_rst_ready got=%b exp=0", s.ir); end
        rst = 1'b0;
        cycle(1'b0, 16'h0000, 1'b1, s);
        total++;
        if (s.ov !== 1'b0 || s.ec !== 8'd0 || s.ir !== 1'b1) begin
            bad++;
            $display("FAIL flush_after got v=%b ec=%0d ir=%b exp v=0 ec=0 ir=1", s.ov, s.ec, s.ir);
        end
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 16'h0000, 1'b1, s);
            total++; if (s.ov !== 1'b0) begin bad++; $display("FAIL flush_ghost c=%0d got v=%b exp=0", c, s.ov); end
        end
    endtask

    task automatic test_errcnt_sat;
        int exp_sat [5];
        logic ov;
        logic [1:0] ec;
        exp_sat = '{1, 2, 3, 3, 3};
        bus2.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus2.in_valid = (c < 5);
            bus2.datain   = 16'h0000;
            #2;
            ov = bus2.out_valid;
            ec = bus2.err_count;
            if (c == 2) begin
                total++; if (ov !== 1'b1 || ec !== 2'd0) begin bad++; $display("FAIL sat_first got v=%b ec=%0d exp v=1 ec=0", ov, ec); end
            end
            if (c >= 3) begin
                total++; if (ec !== 2'(exp_sat[c-3])) begin bad++; $display("FAIL sat_count n=%0d got=%0d exp=%0d", c - 3, ec, exp_sat[c-3]); end
            end
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.datain     = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.datain    = '0;
        bus2.out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sweep();
        test_illegal();
        test_backpressure();
        test_random();
        test_reset_flush();
        test_errcnt_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
